ex_mem_wb_forward_unit: RTL and testbench

//  Producer side of the EX-stage operand-forwarding interface. Holds the EX/MEM and MEM/WB

---
 rtl/ex_mem_wb_forward_unit.sv | 143 ++++++++++++++
 tb/tb_ex_mem_wb_forward_unit.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/ex_mem_wb_forward_unit.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : ex_mem_wb_forward_unit
// Brief    : EX/MEM and MEM/WB pipeline registers, EX operand forwarding select
//            and load-use hazard flag. Optional macro: LOAD_USE_DETECT_EN.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module ex_mem_wb_forward_unit #(
   parameter int DATA_W     = 32,
   parameter int REG_ADDR_W = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [REG_ADDR_W-1:0] if_id_rs,
   input  logic [REG_ADDR_W-1:0] if_id_rt,
   input  logic [REG_ADDR_W-1:0] id_ex_rs,
   input  logic [REG_ADDR_W-1:0] id_ex_rt,
   input  logic [REG_ADDR_W-1:0] id_ex_rd,
   input  logic                  id_ex_reg_write,
   input  logic                  id_ex_mem_read,
   input  logic                  id_ex_mem_write,
   input  logic                  id_ex_mem_to_reg,
   input  logic                  ex_bubble,
   input  logic [DATA_W-1:0]     ex_alu_result,
   input  logic [DATA_W-1:0]     ex_write_data,
   input  logic [DATA_W-1:0]     mem_read_data,
   output logic [1:0]            ForwardA,
   output logic [1:0]            ForwardB,
   output logic [DATA_W-1:0]     EX_MEM_alu_result,
   output logic [DATA_W-1:0]     EX_MEM_write_data,
   output logic [REG_ADDR_W-1:0] EX_MEM_rd,
   output logic                  EX_MEM_reg_write,
   output logic                  EX_MEM_mem_read,
   output logic                  EX_MEM_mem_write,
   output logic                  EX_MEM_mem_to_reg,
   output logic [DATA_W-1:0]     MEM_WB_read_data,
   output logic [REG_ADDR_W-1:0] MEM_WB_rd,
   output logic                  MEM_WB_reg_write,
   output logic                  hazard_stall
);

   localparam logic [1:0] FWD_REGFILE = 2'b00;
   localparam logic [1:0] FWD_EX_MEM  = 2'b10;
   localparam logic [1:0] FWD_MEM_WB  = 2'b01;

   logic [DATA_W-1:0]     ex_mem_alu_result_q, ex_mem_alu_result_d;
   logic [DATA_W-1:0]     ex_mem_write_data_q, ex_mem_write_data_d;
   logic [REG_ADDR_W-1:0] ex_mem_rd_q,         ex_mem_rd_d;
   logic                  ex_mem_reg_write_q,  ex_mem_reg_write_d;
   logic                  ex_mem_mem_read_q,   ex_mem_mem_read_d;
   logic                  ex_mem_mem_write_q,  ex_mem_mem_write_d;
   logic                  ex_mem_mem_to_reg_q, ex_mem_mem_to_reg_d;
   logic [DATA_W-1:0]     mem_wb_read_data_q,  mem_wb_read_data_d;
   logic [REG_ADDR_W-1:0] mem_wb_rd_q,         mem_wb_rd_d;
   logic                  mem_wb_reg_write_q,  mem_wb_reg_write_d;

   // A bubble squashes the whole EX/MEM entry; data fields are zeroed too.
   always_comb begin
      ex_mem_alu_result_d = ex_alu_result;
      ex_mem_write_data_d = ex_write_data;
      ex_mem_rd_d         = id_ex_rd;
      ex_mem_reg_write_d  = id_ex_reg_write;
      ex_mem_mem_read_d   = id_ex_mem_read;
      ex_mem_mem_write_d  = id_ex_mem_write;
      ex_mem_mem_to_reg_d = id_ex_mem_to_reg;
      if (ex_bubble) begin
         ex_mem_alu_result_d = '0;
         ex_mem_write_data_d = '0;
         ex_mem_rd_d         = '0;
         ex_mem_reg_write_d  = 1'b0;
         ex_mem_mem_read_d   = 1'b0;
         ex_mem_mem_write_d  = 1'b0;
         ex_mem_mem_to_reg_d = 1'b0;
      end
      mem_wb_read_data_d = ex_mem_mem_to_reg_q ? mem_read_data : ex_mem_alu_result_q;
      mem_wb_rd_d        = ex_mem_rd_q;
      mem_wb_reg_write_d = ex_mem_reg_write_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ex_mem_alu_result_q <= '0;
         ex_mem_write_data_q <= '0;
         ex_mem_rd_q         <= '0;
         ex_mem_reg_write_q  <= 1'b0;
         ex_mem_mem_read_q   <= 1'b0;
         ex_mem_mem_write_q  <= 1'b0;
         ex_mem_mem_to_reg_q <= 1'b0;
         mem_wb_read_data_q  <= '0;
         mem_wb_rd_q         <= '0;
         mem_wb_reg_write_q  <= 1'b0;
      end else begin
         ex_mem_alu_result_q <= ex_mem_alu_result_d;
         ex_mem_write_data_q <= ex_mem_write_data_d;
         ex_mem_rd_q         <= ex_mem_rd_d;
         ex_mem_reg_write_q  <= ex_mem_reg_write_d;
         ex_mem_mem_read_q   <= ex_mem_mem_read_d;
         ex_mem_mem_write_q  <= ex_mem_mem_write_d;
         ex_mem_mem_to_reg_q <= ex_mem_mem_to_reg_d;
         mem_wb_read_data_q  <= mem_wb_read_data_d;
         mem_wb_rd_q         <= mem_wb_rd_d;
         mem_wb_reg_write_q  <= mem_wb_reg_write_d;
      end
   end

   logic ex_mem_can_fwd;
   logic mem_wb_can_fwd;

   // Loads in EX/MEM never forward; the newer EX/MEM producer beats MEM/WB.
   always_comb begin
      ex_mem_can_fwd = ex_mem_reg_write_q && !ex_mem_mem_read_q && (ex_mem_rd_q != '0);
      mem_wb_can_fwd = mem_wb_reg_write_q && (mem_wb_rd_q != '0);
      ForwardA = FWD_REGFILE;
      ForwardB = FWD_REGFILE;
      if (ex_mem_can_fwd && (ex_mem_rd_q == id_ex_rs))      ForwardA = FWD_EX_MEM;
      else if (mem_wb_can_fwd && (mem_wb_rd_q == id_ex_rs)) ForwardA = FWD_MEM_WB;
      if (ex_mem_can_fwd && (ex_mem_rd_q == id_ex_rt))      ForwardB = FWD_EX_MEM;
      else if (mem_wb_can_fwd && (mem_wb_rd_q == id_ex_rt)) ForwardB = FWD_MEM_WB;
   end

`ifdef LOAD_USE_DETECT_EN
   // Held low while in reset so the stall flag matches the empty pipeline.
   assign hazard_stall = !rst && id_ex_mem_read && (id_ex_rd != '0) &&
                         ((id_ex_rd == if_id_rs) || (id_ex_rd == if_id_rt));
`else
   logic unused_hazard_inputs;
   assign unused_hazard_inputs = ^{if_id_rs, if_id_rt};
   assign hazard_stall = 1'b0;
`endif

   assign EX_MEM_alu_result = ex_mem_alu_result_q;
   assign EX_MEM_write_data = ex_mem_write_data_q;
   assign EX_MEM_rd         = ex_mem_rd_q;
   assign EX_MEM_reg_write  = ex_mem_reg_write_q;
   assign EX_MEM_mem_read   = ex_mem_mem_read_q;
   assign EX_MEM_mem_write  = ex_mem_mem_write_q;
   assign EX_MEM_mem_to_reg = ex_mem_mem_to_reg_q;
   assign MEM_WB_read_data  = mem_wb_read_data_q;
   assign MEM_WB_rd         = mem_wb_rd_q;
   assign MEM_WB_reg_write  = mem_wb_reg_write_q;

endmodule
`default_nettype wire

// File: tb/tb_ex_mem_wb_forward_unit.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : tb_ex_mem_wb_forward_unit
// Brief    : Random plus directed stimulus for ex_mem_wb_forward_unit against a
//            producer-history reference model.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_ex_mem_wb_forward_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic [4:0]  if_id_rs, if_id_rt, id_ex_rs, id_ex_rt, id_ex_rd;
   logic        id_ex_reg_write, id_ex_mem_read, id_ex_mem_write, id_ex_mem_to_reg;
   logic        ex_bubble;
   logic [31:0] ex_alu_result, ex_write_data, mem_read_data;
   logic [1:0]  ForwardA, ForwardB;
   logic [31:0] EX_MEM_alu_result, EX_MEM_write_data, MEM_WB_read_data;
   logic [4:0]  EX_MEM_rd, MEM_WB_rd;
   logic        EX_MEM_reg_write, EX_MEM_mem_read, EX_MEM_mem_write, EX_MEM_mem_to_reg;
   logic        MEM_WB_reg_write, hazard_stall;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   ex_mem_wb_forward_unit #(.DATA_W(32), .REG_ADDR_W(5)) dut (
      .clk(clk), .rst(rst),
      .if_id_rs(if_id_rs), .if_id_rt(if_id_rt),
      .id_ex_rs(id_ex_rs), .id_ex_rt(id_ex_rt), .id_ex_rd(id_ex_rd),
      .id_ex_reg_write(id_ex_reg_write), .id_ex_mem_read(id_ex_mem_read),
      .id_ex_mem_write(id_ex_mem_write), .id_ex_mem_to_reg(id_ex_mem_to_reg),
      .ex_bubble(ex_bubble), .ex_alu_result(ex_alu_result),
      .ex_write_data(ex_write_data), .mem_read_data(mem_read_data),
      .ForwardA(ForwardA), .ForwardB(ForwardB),
      .EX_MEM_alu_result(EX_MEM_alu_result), .EX_MEM_write_data(EX_MEM_write_data),
      .EX_MEM_rd(EX_MEM_rd), .EX_MEM_reg_write(EX_MEM_reg_write),
      .EX_MEM_mem_read(EX_MEM_mem_read), .EX_MEM_mem_write(EX_MEM_mem_write),
      .EX_MEM_mem_to_reg(EX_MEM_mem_to_reg),
      .MEM_WB_read_data(MEM_WB_read_data), .MEM_WB_rd(MEM_WB_rd),
      .MEM_WB_reg_write(MEM_WB_reg_write), .hazard_stall(hazard_stall)
   );

   // Reference: history of in-flight instructions, index 0 = one stage ahead of EX.
   typedef struct {
      logic [4:0]  rd;
      logic        rw, mr, mw, m2r;
      logic [31:0] alu, wd;
      logic [31:0] result;
   } instr_t;

   instr_t hist [2];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic instr_t empty_instr();
      instr_t e;
      e.rd = '0; e.rw = 1'b0; e.mr = 1'b0; e.mw = 1'b0; e.m2r = 1'b0;
      e.alu = '0; e.wd = '0; e.result = '0;
      return e;
   endfunction

   // Scan producers newest first; the first eligible match supplies the operand.
   function automatic logic [1:0] ref_fwd(input logic [4:0] src);
      for (int age = 0; age < 2; age++) begin
         if (hist[age].rw && hist[age].rd != 0 && hist[age].rd == src &&
             !(age == 0 && hist[age].mr))
            return (age == 0) ? 2'b10 : 2'b01;
      end
      return 2'b00;
   endfunction

   function automatic logic ref_stall();
`ifdef LOAD_USE_DETECT_EN
      return !rst && id_ex_mem_read && id_ex_rd != 0 &&
             (id_ex_rd == if_id_rs || id_ex_rd == if_id_rt);
`else
      return 1'b0;
`endif
   endfunction

   task automatic model_edge();
      instr_t n;
      if (rst) begin
         hist[0] = empty_instr();
         hist[1] = empty_instr();
         return;
      end
      hist[1] = hist[0];
      hist[1].result = hist[0].m2r ? mem_read_data : hist[0].alu;
      n = empty_instr();
      if (!ex_bubble) begin
         n.rd = id_ex_rd; n.rw = id_ex_reg_write; n.mr = id_ex_mem_read;
         n.mw = id_ex_mem_write; n.m2r = id_ex_mem_to_reg;
         n.alu = ex_alu_result; n.wd = ex_write_data;
      end
      hist[0] = n;
   endtask

   task automatic check_all();
      check("ForwardA", 32'(ForwardA), 32'(ref_fwd(id_ex_rs)));
      check("ForwardB", 32'(ForwardB), 32'(ref_fwd(id_ex_rt)));
      check("hazard_stall", 32'(hazard_stall), 32'(ref_stall()));
      check("EX_MEM_alu", EX_MEM_alu_result, hist[0].alu);
      check("EX_MEM_wd", EX_MEM_write_data, hist[0].wd);
      check("EX_MEM_rd", 32'(EX_MEM_rd), 32'(hist[0].rd));
      check("EX_MEM_ctrl", 32'({EX_MEM_reg_write, EX_MEM_mem_read, EX_MEM_mem_write, EX_MEM_mem_to_reg}),
            32'({hist[0].rw, hist[0].mr, hist[0].mw, hist[0].m2r}));
      check("MEM_WB_data", MEM_WB_read_data, hist[1].result);
      check("MEM_WB_rd", 32'(MEM_WB_rd), 32'(hist[1].rd));
      check("MEM_WB_rw", 32'(MEM_WB_reg_write), 32'(hist[1].rw));
   endtask

   // Called at a negedge with inputs already driven: check, then cross one edge.
   task automatic cycle();
      #1;
      check_all();
      @(posedge clk);
      model_edge();
      @(negedge clk);
   endtask

   task automatic set_instr(input logic [4:0] rd, input logic rw, input logic mr,
                            input logic m2r, input logic [31:0] alu);
      id_ex_rd = rd; id_ex_reg_write = rw; id_ex_mem_read = mr;
      id_ex_mem_write = 1'b0; id_ex_mem_to_reg = m2r; ex_bubble = 1'b0;
      ex_alu_result = alu; ex_write_data = $urandom;
   endtask

   task automatic randomize_inputs();
      if_id_rs = 5'($urandom_range(0, 3)); if_id_rt = 5'($urandom_range(0, 3));
      id_ex_rs = 5'($urandom_range(0, 3)); id_ex_rt = 5'($urandom_range(0, 3));
      id_ex_rd = 5'($urandom_range(0, 3));
      id_ex_reg_write = 1'($urandom); id_ex_mem_read = 1'($urandom);
      id_ex_mem_write = 1'($urandom); id_ex_mem_to_reg = 1'($urandom);
      ex_bubble = ($urandom_range(0, 5) == 0);
      ex_alu_result = $urandom; ex_write_data = $urandom; mem_read_data = $urandom;
   endtask

   initial begin
      hist[0] = empty_instr();
      hist[1] = empty_instr();
      rst = 1'b1;
      randomize_inputs();
      @(negedge clk);
      #1;
      check_all();
      @(negedge clk);
      rst = 1'b0;
      if_id_rs = 0; if_id_rt = 0; id_ex_rs = 0; id_ex_rt = 0;
      mem_read_data = 32'h0;

      // add r3 producer, then consumer reads r3 via rs
      set_instr(5'd3, 1'b1, 1'b0, 1'b0, 32'h11);
      cycle();
      id_ex_rs = 5'd3; id_ex_rt = 5'd4;
      #1;
      check("t1_fwdA", 32'(ForwardA), 32'h2);
      check("t1_fwdB", 32'(ForwardB), 32'h0);
      // r3 in MEM/WB (0x11) and EX/MEM (0x22): newer wins
      set_instr(5'd3, 1'b1, 1'b0, 1'b0, 32'h22);
      cycle();
      id_ex_rt = 5'd3;
      #1;
      check("t2_fwdB", 32'(ForwardB), 32'h2);
      // destination zero never forwards
      set_instr(5'd0, 1'b1, 1'b0, 1'b0, 32'h33);
      cycle();
      id_ex_rs = 5'd0;
      #1;
      check("t3_fwdA", 32'(ForwardA), 32'h0);
      // lw r5 in EX with IF/ID reading r5, then bubble
      set_instr(5'd5, 1'b1, 1'b1, 1'b1, 32'h40);
      if_id_rt = 5'd5;
      #1;
`ifdef LOAD_USE_DETECT_EN
      check("t4_stall", 32'(hazard_stall), 32'h1);
`else
      check("t4_stall", 32'(hazard_stall), 32'h0);
`endif
      cycle();
      ex_bubble = 1'b1;
      cycle();
      check("t4_bubble", 32'(EX_MEM_reg_write), 32'h0);
      // lw r7 returns 0xDEADBEEF, consumer forwarded from MEM/WB
      if_id_rt = 5'd0;
      set_instr(5'd7, 1'b1, 1'b1, 1'b1, 32'h80);
      cycle();
      set_instr(5'd1, 1'b1, 1'b0, 1'b0, 32'h5);
      mem_read_data = 32'hDEADBEEF;
      cycle();
      id_ex_rs = 5'd7;
      #1;
      check("t5_data", MEM_WB_read_data, 32'hDEADBEEF);
      check("t5_rd", 32'(MEM_WB_rd), 32'h7);
      check("t5_fwdA", 32'(ForwardA), 32'h1);

      for (int i = 0; i < 400; i++) begin
         randomize_inputs();
         cycle();
         if (i == 200) begin
            // async reset between edges with a live pipeline
            #2;
            rst = 1'b1;
            model_edge();
            #1;
            check_all();
            @(posedge clk);
            model_edge();
            @(negedge clk);
            check_all();
            rst = 1'b0;
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
